// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//    Shares a single UART transmitter among NUM_REQ on-chip producers using
//    round-robin arbitration. Each frame goes through four stages: accept the
//    winning payload, launch it with a one-cycle strobe, follow the
//    transmitter's busy flag, and report completion to the owning requester.
//
// Optional feature (macro UART_ARB_GAP_EN):
//    When defined, a GAP state holds the arbiter idle for GAP_CYCLES clock
//    cycles after every DONE, before the next grant can be issued.
//    When undefined, the GAP state and its counter do not exist and a new
//    grant may follow DONE on the very next cycle.
//
// Parameters:
//    NUM_REQ     number of requesters (2..8)
//    DATA_WIDTH  payload width, equal to the UART data width
//    GAP_CYCLES  idle cycles forced between frames (only with UART_ARB_GAP_EN)
//
// Ports:
//    CLK            in   clock, shared with the UART transmitter
//    RST            in   synchronous reset, active-low
//    REQ            in   per-requester request level, held until GNT
//    REQ_DATA       in   packed payloads, slice i = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH]
//    busy           in   UART transmitter busy flag
//    TX_Data_Valid  out  one-cycle launch strobe to the transmitter
//    TX_IN          out  payload to the transmitter, stable until DONE
//    GNT            out  one-hot, one-cycle pulse: payload of requester i taken
//    DONE           out  one-hot, one-cycle pulse: frame of requester i finished
//    OWNER          out  index of the current / last granted requester
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic [NUM_REQ-1:0]              REQ,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_DATA,
   input  logic                            busy,
   output logic                            TX_Data_Valid,
   output logic [DATA_WIDTH-1:0]           TX_IN,
   output logic [NUM_REQ-1:0]              GNT,
   output logic [NUM_REQ-1:0]              DONE,
   output logic [$clog2(NUM_REQ)-1:0]      OWNER
);

   localparam int PW = $clog2(NUM_REQ);

`ifdef UART_ARB_GAP_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      SEND   = 2'd2,
      GAP    = 2'd3
   } state_t;

   // The counter only ever holds GAP_CYCLES-1 down to 0.
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`else
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      SEND   = 2'd2
   } state_t;
`endif

   state_t                 state_q, state_d;
   logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]          owner_q, owner_d;
   logic [DATA_WIDTH-1:0]  tx_in_q, tx_in_d;
   logic                   tx_valid_q, tx_valid_d;
   logic [NUM_REQ-1:0]     gnt_q, gnt_d;
   logic [NUM_REQ-1:0]     done_q, done_d;

   logic                   win_found;
   logic [PW-1:0]          win_idx;
   logic [PW-1:0]          cand;
   logic [DATA_WIDTH-1:0]  win_data;

   // Round-robin pick: scan starting one past the last winner so that the
   // requester just served ends up with the lowest priority.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      win_data  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!win_found && REQ[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == PW'(i)) begin
            win_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Frame sequencer. Strobes (valid, grant, done) default low so each one
   // lasts a single cycle; payload and owner hold until the next grant.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      tx_in_d    = tx_in_q;
      tx_valid_d = 1'b0;
      gnt_d      = '0;
      done_d     = '0;
`ifdef UART_ARB_GAP_EN
      gap_cnt_d  = gap_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            // A busy transmitter here means a frame we did not launch is
            // still running, so hold off.
            if (win_found && !busy) begin
               tx_in_d    = win_data;
               tx_valid_d = 1'b1;
               owner_d    = win_idx;
               rr_ptr_d   = win_idx;
               for (int i = 0; i < NUM_REQ; i++) begin
                  gnt_d[i] = (win_idx == PW'(i));
               end
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            if (busy) begin
               state_d = SEND;
            end
         end
         SEND: begin
            if (!busy) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  done_d[i] = (owner_q == PW'(i));
               end
`ifdef UART_ARB_GAP_EN
               if (GAP_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  gap_cnt_d = GW'(GAP_CYCLES - 1);
                  state_d   = GAP;
               end
`else
               state_d = IDLE;
`endif
            end
         end
`ifdef UART_ARB_GAP_EN
         GAP: begin
            // The DONE cycle is the first gap cycle, so IDLE is reached
            // exactly GAP_CYCLES cycles after DONE.
            if (gap_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - GW'(1);
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. Reset abandons any frame in flight without
   // reporting DONE and points the arbiter so requester 0 wins first.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= IDLE;
         rr_ptr_q   <= PW'(NUM_REQ - 1);
         owner_q    <= '0;
         tx_in_q    <= '0;
         tx_valid_q <= 1'b0;
         gnt_q      <= '0;
         done_q     <= '0;
`ifdef UART_ARB_GAP_EN
         gap_cnt_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         tx_in_q    <= tx_in_d;
         tx_valid_q <= tx_valid_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
`ifdef UART_ARB_GAP_EN
         gap_cnt_q  <= gap_cnt_d;
`endif
      end
   end

   assign TX_Data_Valid = tx_valid_q;
   assign TX_IN         = tx_in_q;
   assign GNT           = gnt_q;
   assign DONE          = done_q;
   assign OWNER         = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (NUM_REQ=4, DATA_WIDTH=8, GAP_CYCLES=3).
// Inputs change and outputs are sampled on the falling clock edge; the busy
// flag of the UART transmitter is driven directly by the scenario tasks.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 8;
   localparam int GAP_CYCLES = 3;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [3:0]  REQ = 4'b0000;
   logic [31:0] REQ_DATA = {8'h3C, 8'hA5, 8'h5A, 8'h11};
   logic        busy = 1'b0;
   logic        TX_Data_Valid;
   logic [7:0]  TX_IN;
   logic [3:0]  GNT;
   logic [3:0]  DONE;
   logic [1:0]  OWNER;

   int checks   = 0;
   int failures = 0;

   uart_tx_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DATA_WIDTH),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .REQ           (REQ),
      .REQ_DATA      (REQ_DATA),
      .busy          (busy),
      .TX_Data_Valid (TX_Data_Valid),
      .TX_IN         (TX_IN),
      .GNT           (GNT),
      .DONE          (DONE),
      .OWNER         (OWNER)
   );

   // 10 ns clock
   always #5 CLK = ~CLK;

   // Advance to the next falling edge, where outputs are stable.
   task automatic step();
      @(negedge CLK);
   endtask

   // Two-cycle reset with no requests pending.
   task automatic do_reset();
      RST  = 1'b0;
      REQ  = 4'b0000;
      busy = 1'b0;
      step();
      step();
      RST = 1'b1;
   endtask

   // Wait for a grant, run one frame with busy high for 3 cycles, and return
   // at the falling edge where DONE is visible.
   task automatic serve(output logic [3:0] g, output logic [7:0] txd,
                        output logic [3:0] d, output int waited);
      g      = 4'b0000;
      d      = 4'b0000;
      txd    = 8'h00;
      waited = 0;
      for (int i = 0; i < 20 && g == 4'b0000; i++) begin
         step();
         waited++;
         if (GNT !== 4'b0000) begin
            g   = GNT;
            txd = TX_IN;
         end
      end
      if (g == 4'b0000) begin
         checks++;
         failures++;
         $display("[TB] FAIL serve_grant_timeout: GNT stayed %b, required a grant", GNT);
         return;
      end
      REQ  = REQ & ~g;
      busy = 1'b1;
      repeat (3) step();
      busy = 1'b0;
      for (int i = 0; i < 10 && d == 4'b0000; i++) begin
         step();
         d = DONE;
      end
   endtask

   task automatic test_reset();
      RST  = 1'b0;
      REQ  = 4'b1111;
      busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({TX_Data_Valid, TX_IN, GNT, DONE, OWNER} !== 19'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs_zero cycle %0d: got valid=%b tx=%h gnt=%b done=%b owner=%0d, required all 0",
                     i, TX_Data_Valid, TX_IN, GNT, DONE, OWNER);
         end
      end
      RST = 1'b1;
      step();
      checks++;
      if (GNT !== 4'b0001 || TX_Data_Valid !== 1'b1 || OWNER !== 2'd0 || TX_IN !== 8'h11) begin
         failures++;
         $display("[TB] FAIL reset_first_grant: got gnt=%b valid=%b owner=%0d tx=%h, required gnt=0001 valid=1 owner=0 tx=11",
                  GNT, TX_Data_Valid, OWNER, TX_IN);
      end
      REQ  = 4'b0000;
      busy = 1'b1;
      step();
      checks++;
      if (GNT !== 4'b0000 || TX_Data_Valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_strobe_width: got gnt=%b valid=%b, required gnt=0000 valid=0", GNT, TX_Data_Valid);
      end
      repeat (2) step();
      busy = 1'b0;
      step();
      checks++;
      if (DONE !== 4'b0001) begin
         failures++;
         $display("[TB] FAIL reset_frame_done: got %b, required 0001", DONE);
      end
      step();
      checks++;
      if (DONE !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_done_width: got %b, required 0000", DONE);
      end
   endtask

   task automatic test_single_frame();
      int stray;
      REQ = 4'b0100;
      step();
      checks++;
      if (GNT !== 4'b0100 || TX_Data_Valid !== 1'b1 || TX_IN !== 8'hA5 || OWNER !== 2'd2) begin
         failures++;
         $display("[TB] FAIL single_grant: got gnt=%b valid=%b tx=%h owner=%0d, required gnt=0100 valid=1 tx=a5 owner=2",
                  GNT, TX_Data_Valid, TX_IN, OWNER);
      end
      REQ      = 4'b0000;
      busy     = 1'b1;
      REQ_DATA = {8'h3C, 8'hFF, 8'h5A, 8'h11};
      step();
      checks++;
      if (TX_Data_Valid !== 1'b0 || GNT !== 4'b0000 || TX_IN !== 8'hA5) begin
         failures++;
         $display("[TB] FAIL single_after_launch: got valid=%b gnt=%b tx=%h, required valid=0 gnt=0000 tx=a5",
                  TX_Data_Valid, GNT, TX_IN);
      end
      stray = 0;
      repeat (10) begin
         step();
         if (DONE !== 4'b0000) stray++;
      end
      checks++;
      if (stray != 0) begin
         failures++;
         $display("[TB] FAIL single_done_early: got %0d DONE cycles while busy, required 0", stray);
      end
      busy = 1'b0;
      step();
      checks++;
      if (DONE !== 4'b0100 || TX_IN !== 8'hA5 || OWNER !== 2'd2) begin
         failures++;
         $display("[TB] FAIL single_done: got done=%b tx=%h owner=%0d, required done=0100 tx=a5 owner=2",
                  DONE, TX_IN, OWNER);
      end
      REQ_DATA = {8'h3C, 8'hA5, 8'h5A, 8'h11};
      step();
   endtask

   task automatic test_busy_blocking();
      int stray;
      busy  = 1'b1;
      REQ   = 4'b0010;
      stray = 0;
      repeat (5) begin
         step();
         if (GNT !== 4'b0000) stray++;
      end
      checks++;
      if (stray != 0) begin
         failures++;
         $display("[TB] FAIL busy_block: got %0d grant cycles while busy, required 0", stray);
      end
      busy = 1'b0;
      step();
      checks++;
      if (GNT !== 4'b0010 || TX_IN !== 8'h5A) begin
         failures++;
         $display("[TB] FAIL busy_release_grant: got gnt=%b tx=%h, required gnt=0010 tx=5a", GNT, TX_IN);
      end
      REQ  = 4'b0000;
      busy = 1'b1;
      repeat (2) step();
      busy = 1'b0;
      step();
      checks++;
      if (DONE !== 4'b0010) begin
         failures++;
         $display("[TB] FAIL busy_frame_done: got %b, required 0010", DONE);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] g, d;
      logic [7:0] txd;
      int         waited;
      logic [3:0] exp_g [5];
      logic [7:0] exp_tx [5];
      exp_g  = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};
      exp_tx = '{8'h11, 8'h5A, 8'h3C, 8'h11, 8'h5A};
      do_reset();
      REQ = 4'b1011;
      for (int n = 0; n < 5; n++) begin
         if (n == 3) REQ = 4'b0011;
         serve(g, txd, d, waited);
         checks++;
         if (g !== exp_g[n] || txd !== exp_tx[n] || d !== exp_g[n]) begin
            failures++;
            $display("[TB] FAIL rr_order frame %0d: got gnt=%b tx=%h done=%b, required gnt=%b tx=%h done=%b",
                     n, g, txd, d, exp_g[n], exp_tx[n], exp_g[n]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] g, d;
      logic [7:0] txd;
      int         waited;
      int         exp_wait;
`ifdef UART_ARB_GAP_EN
      exp_wait = 1 + GAP_CYCLES;
`else
      exp_wait = 1;
`endif
      do_reset();
      REQ = 4'b0011;
      serve(g, txd, d, waited);
      checks++;
      if (g !== 4'b0001 || d !== 4'b0001 || waited != 1) begin
         failures++;
         $display("[TB] FAIL b2b_first: got gnt=%b done=%b latency=%0d, required gnt=0001 done=0001 latency=1",
                  g, d, waited);
      end
      checks++;
      if (GNT !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL b2b_done_gnt_overlap: got gnt=%b with DONE, required 0000", GNT);
      end
      serve(g, txd, d, waited);
      checks++;
      if (g !== 4'b0010 || waited != exp_wait) begin
         failures++;
         $display("[TB] FAIL b2b_spacing: got gnt=%b after %0d cycles, required gnt=0010 after %0d cycles",
                  g, waited, exp_wait);
      end
   endtask

   task automatic test_reset_mid_send();
      int stray;
      REQ = 4'b0001;
      step();
      checks++;
      if (GNT !== 4'b0001) begin
         failures++;
         $display("[TB] FAIL midsend_grant: got %b, required 0001", GNT);
      end
      REQ  = 4'b0000;
      busy = 1'b1;
      repeat (2) step();
      RST = 1'b0;
      step();
      checks++;
      if ({TX_Data_Valid, TX_IN, GNT, DONE, OWNER} !== 19'd0) begin
         failures++;
         $display("[TB] FAIL midsend_reset_zero: got valid=%b tx=%h gnt=%b done=%b owner=%0d, required all 0",
                  TX_Data_Valid, TX_IN, GNT, DONE, OWNER);
      end
      RST   = 1'b1;
      REQ   = 4'b0100;
      stray = 0;
      repeat (3) begin
         step();
         if (GNT !== 4'b0000 || DONE !== 4'b0000) stray++;
      end
      checks++;
      if (stray != 0) begin
         failures++;
         $display("[TB] FAIL midsend_no_activity: got %0d cycles with GNT or DONE, required 0", stray);
      end
      busy = 1'b0;
      step();
      checks++;
      if (GNT !== 4'b0100 || OWNER !== 2'd2) begin
         failures++;
         $display("[TB] FAIL midsend_regrant: got gnt=%b owner=%0d, required gnt=0100 owner=2", GNT, OWNER);
      end
      REQ  = 4'b0000;
      busy = 1'b1;
      repeat (2) step();
      busy = 1'b0;
      step();
      checks++;
      if (DONE !== 4'b0100) begin
         failures++;
         $display("[TB] FAIL midsend_final_done: got %b, required 0100", DONE);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_busy_blocking();
      test_round_robin();
      test_back_to_back();
      test_reset_mid_send();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
